round_judge: RTL and testbench
==============================

ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 Parameter WINDOW_TICKS, default 8: number of tick pulses allowed for a response.
REQ-002 Parameter ROUNDS, default 32: number of rounds per game.
REQ-003 Parameter SEED, default 8'hA5: LFSR value loaded at reset.
REQ-004 clk  input  1  single system clock; all state on its rising edge.
REQ-005 res  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  begin a game; one-cycle pulse, honoured only in IDLE or OVER.
REQ-007 btn  input  4  debounced, clk-synchronous player buttons, one bit per finger.
REQ-008 tick  input  1  one-clk-wide time-base pulse.
REQ-009 pattern  output  4  target finger pattern for the display stage; 0 when no round is active.
REQ-010 score  output  8  running score for the display stage.
REQ-011 C  output  1  result of the last judged round: 1 = hit, 0 = miss.
REQ-012 playing  output  1  high in LOAD, ARMED and RELEASE.
REQ-013 game_over  output  1  high in OVER.

Function
REQ-014 States: IDLE, LOAD, ARMED, RELEASE, OVER; all outputs registered.
REQ-015 IDLE: pattern=0; start -> LOAD with score=0, round count=0, streak=0.
REQ-016 LOAD (exactly 1 cycle): lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}; pattern <= new lfsr[3:0], or 4'b0001 if that nibble is 0; timer <= WINDOW_TICKS; -> ARMED.
REQ-017 ARMED, first cycle with btn != 0: capture btn; hit if btn == pattern; C and score update on the next edge; -> RELEASE.
REQ-018 ARMED, btn == 0 and tick: decrement timer; when timer reaches 0 -> miss (C=0, score unchanged, streak=0) -> RELEASE.
REQ-019 Same-cycle btn != 0 and final tick: btn takes priority and is judged.
REQ-020 Hit: score += 1, saturating at 255; streak += 1, saturating at 15.
REQ-021 Wrong pattern: miss, same as REQ-018.
REQ-022 RELEASE: pattern=0; wait until btn == 0, then round count += 1; if round count == ROUNDS -> OVER, else -> LOAD.
REQ-023 OVER: pattern=0; score and C hold; start -> LOAD with score, round count and streak cleared (LFSR not reseeded).
REQ-024 start outside IDLE/OVER is ignored; tick outside ARMED is ignored.

Reset
REQ-025 On res low, immediately: state=IDLE, pattern=0, score=0, C=0, playing=0, game_over=0, lfsr=SEED, timer=0, round count=0, streak=0.
REQ-026 Reset mid-game aborts the round with no score update; after res rises the block waits for start.

Configuration
REQ-027 Macro STREAK_BONUS_EN defined: a hit with streak >= 3 before the hit adds 2 (saturating at 255); a miss clears the streak.
REQ-028 STREAK_BONUS_EN undefined: every hit adds 1; streak logic absent.

Verification
REQ-029 Reset, start, press btn=4'hA in ARMED -> first pattern 4'hA (lfsr 8'h4A); C=1, score=1; second pattern 4'h5 (lfsr 8'h95).
REQ-030 No button for 8 ticks -> C=0, score unchanged, RELEASE then LOAD; 7 ticks alone do not time out.
REQ-031 btn=4'h3 against pattern 4'hA -> C=0, score holds; btn held through RELEASE -> no LOAD until btn=0.
REQ-032 ROUNDS=2, two hits -> game_over=1, score=2, pattern=0; start -> score=0, playing=1.
REQ-033 Preload score 254, two hits -> score 255 and saturated; with STREAK_BONUS_EN, hits 1-5 -> score 1,2,3,5,7.
REQ-034 Assert res low mid-ARMED -> all outputs reset the same cycle; start after release -> pattern 4'hA again.

Source files
------------

// File: rtl/round_judge.sv
// round_judge: reaction game controller. Every round it shows a pseudo-random
// finger pattern, then waits a limited number of time-base ticks for a button
// press. The press is judged as hit or miss, the score is updated, and the
// block waits for all buttons to be released before it starts the next round.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   res        asynchronous active-low reset
//   start      one-cycle pulse that starts a game (honoured in IDLE or OVER)
//   btn[3:0]   debounced player buttons, synchronous to clk
//   tick       one-clk-wide time-base pulse
//   pattern    target pattern for the display, 0 when no round is active
//   score      running score, saturating at 255
//   C          result of the last judged round (1 = hit, 0 = miss)
//   playing    high while a game is running (LOAD, ARMED, RELEASE)
//   game_over  high in OVER
//
// Optional feature macro: STREAK_BONUS_EN. When it is defined, a hit scores 2
// once at least three consecutive hits precede it, and a miss clears the streak.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | step the LFSR and present a new pattern (one cycle)
// ARMED   | waiting for a press or for the response window to run out
// RELEASE | round judged, waiting for all buttons to be released
// OVER    | all rounds played, score and C hold until start
module round_judge #(
  parameter int          WINDOW_TICKS = 8,
  parameter int          ROUNDS       = 32,
  parameter logic [7:0]  SEED         = 8'hA5
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [3:0] btn,
  input  logic       tick,
  output logic [3:0] pattern,
  output logic [7:0] score,
  output logic       C,
  output logic       playing,
  output logic       game_over
);

  localparam int TW = $clog2(WINDOW_TICKS + 1);
  localparam int RW = $clog2(ROUNDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_RELEASE, S_OVER} state_t;

  state_t          state, state_nx;
  logic [7:0]      lfsr, lfsr_nx, lfsr_step;
  logic [TW-1:0]   timer, timer_nx;
  logic [RW-1:0]   rnd, rnd_nx, rnd_inc;
  logic [3:0]      pattern_nx;
  logic [7:0]      score_nx;
  logic            c_nx;
  logic [1:0]      inc;
  logic [8:0]      sum;
`ifdef STREAK_BONUS_EN
  logic [3:0]      streak, streak_nx;
`endif

  always_comb begin
    state_nx   = state;
    lfsr_nx    = lfsr;
    timer_nx   = timer;
    rnd_nx     = rnd;
    pattern_nx = pattern;
    score_nx   = score;
    c_nx       = C;
    lfsr_step  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    rnd_inc    = rnd + RW'(1);
    inc        = 2'd1;
`ifdef STREAK_BONUS_EN
    streak_nx  = streak;
    if (streak >= 4'd3) inc = 2'd2;
`endif
    sum        = {1'b0, score} + {7'b0, inc};

    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_nx = S_LOAD;
          score_nx = '0;
          rnd_nx   = '0;
`ifdef STREAK_BONUS_EN
          streak_nx = '0;
`endif
        end
      end
      S_LOAD: begin
        lfsr_nx    = lfsr_step;
        // an all-zero target could never be pressed, so it maps to one finger
        pattern_nx = (lfsr_step[3:0] == 4'd0) ? 4'b0001 : lfsr_step[3:0];
        timer_nx   = TW'(WINDOW_TICKS);
        state_nx   = S_ARMED;
      end
      S_ARMED: begin
        // a press wins over a tick arriving in the same cycle
        if (btn != 4'd0) begin
          pattern_nx = '0;
          state_nx   = S_RELEASE;
          if (btn == pattern) begin
            c_nx     = 1'b1;
            score_nx = sum[8] ? 8'hFF : sum[7:0];
`ifdef STREAK_BONUS_EN
            if (streak != 4'hF) streak_nx = streak + 4'd1;
`endif
          end else begin
            c_nx = 1'b0;
`ifdef STREAK_BONUS_EN
            streak_nx = '0;
`endif
          end
        end else if (tick) begin
          timer_nx = timer - TW'(1);
          if (timer <= TW'(1)) begin
            c_nx       = 1'b0;
            pattern_nx = '0;
            state_nx   = S_RELEASE;
`ifdef STREAK_BONUS_EN
            streak_nx = '0;
`endif
          end
        end
      end
      S_RELEASE: begin
        if (btn == 4'd0) begin
          rnd_nx   = rnd_inc;
          state_nx = (rnd_inc == RW'(ROUNDS)) ? S_OVER : S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= S_IDLE;
      lfsr      <= SEED;
      timer     <= '0;
      rnd       <= '0;
      pattern   <= '0;
      score     <= '0;
      C         <= 1'b0;
      playing   <= 1'b0;
      game_over <= 1'b0;
`ifdef STREAK_BONUS_EN
      streak    <= '0;
`endif
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      timer     <= timer_nx;
      rnd       <= rnd_nx;
      pattern   <= pattern_nx;
      score     <= score_nx;
      C         <= c_nx;
      playing   <= (state_nx == S_LOAD) || (state_nx == S_ARMED) || (state_nx == S_RELEASE);
      game_over <= (state_nx == S_OVER);
`ifdef STREAK_BONUS_EN
      streak    <= streak_nx;
`endif
    end
  end

endmodule

// File: tb/tb_round_judge.sv
// Bench for round_judge. Two instances share the stimulus: dut_a plays long
// games (enough rounds to reach score saturation), dut_b has ROUNDS=2 for the
// game-over behaviour. Only one is out of reset at a time; the other must show
// reset values. A game-level model tracks expected outputs.
module tb_round_judge;

  localparam int WIN = 8;
  localparam int RA  = 300;
  localparam int RB  = 2;

  logic       clk = 1'b0;
  logic       res_a, res_b, start, tick;
  logic [3:0] btn;
  logic [3:0] pat_a, pat_b;
  logic [7:0] score_a, score_b;
  logic       c_a, c_b, play_a, play_b, over_a, over_b;

  round_judge #(.WINDOW_TICKS(WIN), .ROUNDS(RA)) dut_a (
    .clk(clk), .res(res_a), .start(start), .btn(btn), .tick(tick),
    .pattern(pat_a), .score(score_a), .C(c_a), .playing(play_a), .game_over(over_a));

  round_judge #(.WINDOW_TICKS(WIN), .ROUNDS(RB)) dut_b (
    .clk(clk), .res(res_b), .start(start), .btn(btn), .tick(tick),
    .pattern(pat_b), .score(score_b), .C(c_b), .playing(play_b), .game_over(over_b));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int sel = 0;

  logic [7:0] m_lfsr;
  logic [3:0] m_pat;
  int         m_score, m_streak, m_round, m_ticks, m_rounds;
  bit         m_c, m_play, m_over;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] pat_of(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? 4'd1 : v[3:0];
  endfunction

  task automatic model_reset();
    m_lfsr = 8'hA5; m_pat = 4'd0; m_score = 0; m_streak = 0;
    m_round = 0; m_ticks = 0; m_c = 1'b0; m_play = 1'b0; m_over = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (sel == 0) begin
        chk("a_pattern", pat_a, m_pat);
        chk("a_score", score_a, m_score);
        chk("a_c", c_a, m_c);
        chk("a_playing", play_a, m_play);
        chk("a_game_over", over_a, m_over);
        chk("b_idle_outputs", {pat_b, score_b, c_b, play_b, over_b}, 0);
      end else begin
        chk("b_pattern", pat_b, m_pat);
        chk("b_score", score_b, m_score);
        chk("b_c", c_b, m_c);
        chk("b_playing", play_b, m_play);
        chk("b_game_over", over_b, m_over);
        chk("a_idle_outputs", {pat_a, score_a, c_a, play_a, over_a}, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    m_lfsr  = lfsr_next(m_lfsr);
    m_pat   = pat_of(m_lfsr);
    m_ticks = 0;
  endtask

  // start pulse, one LOAD cycle, then the round is armed
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0; m_round = 0; m_streak = 0; m_play = 1'b1; m_over = 1'b0;
    step();
    arm();
  endtask

  task automatic press(input logic [3:0] b, input logic t);
    int add;
    btn  = b;
    tick = t;
    step();
    tick = 1'b0;
    if (b == m_pat) begin
      add = 1;
`ifdef STREAK_BONUS_EN
      if (m_streak >= 3) add = 2;
`endif
      m_score  = (m_score + add > 255) ? 255 : m_score + add;
      m_streak = (m_streak < 15) ? m_streak + 1 : 15;
      m_c      = 1'b1;
    end else begin
      m_c      = 1'b0;
      m_streak = 0;
    end
    m_pat = 4'd0;
  endtask

  task automatic release_btn();
    btn = 4'd0;
    step();
    m_round++;
    if (m_round == m_rounds) begin
      m_play = 1'b0;
      m_over = 1'b1;
    end else begin
      step();
      arm();
    end
  endtask

  // tick pulses separated by a quiet cycle; the window closes on tick WIN
  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      m_ticks++;
      if (m_ticks == WIN) begin
        m_c = 1'b0; m_streak = 0; m_pat = 4'd0;
      end else begin
        step();
      end
    end
  endtask

  int exp5 [5];

  initial begin
`ifdef STREAK_BONUS_EN
    exp5 = '{1, 2, 3, 5, 7};
`else
    exp5 = '{1, 2, 3, 4, 5};
`endif
    res_a = 1'b0; res_b = 1'b0; start = 1'b0; tick = 1'b0; btn = 4'd0;
    model_reset();
    sel = 0;
    m_rounds = RA;
    #1 chk_en = 1'b1;
    step(); step();
    res_a = 1'b1;
    step();

    do_start();
    chk("first_pattern", pat_a, 4'hA);
    chk("first_lfsr_model", m_lfsr, 8'h4A);
    press(4'hA, 1'b0);
    chk("hit_c", c_a, 1);
    chk("hit_score", score_a, 1);
    release_btn();
    chk("second_pattern", pat_a, 4'h5);
    chk("second_lfsr_model", m_lfsr, 8'h95);

    pulse_ticks(7);
    chk("seven_ticks_still_armed", pat_a, 4'h5);
    pulse_ticks(1);
    chk("timeout_c", c_a, 0);
    chk("timeout_score", score_a, 1);
    chk("timeout_pattern", pat_a, 0);
    release_btn();
    chk("third_pattern", pat_a, 4'hA);

    press(4'h3, 1'b0);
    chk("wrong_c", c_a, 0);
    chk("wrong_score", score_a, 1);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; start = 1'b1;
      step();
      tick = 1'b0; start = 1'b0;
    end
    chk("held_no_load_pattern", pat_a, 0);
    chk("held_playing", play_a, 1);
    release_btn();

    pulse_ticks(7);
    press(m_pat, 1'b1);
    chk("final_tick_press_c", c_a, 1);
    chk("final_tick_press_score", score_a, 2);
    release_btn();

    start = 1'b1;
    step();
    start = 1'b0;

    #2 res_a = 1'b0;
    #1;
    chk("async_reset_outputs", {pat_a, score_a, c_a, play_a, over_a}, 0);
    model_reset();
    step(); step();
    res_a = 1'b1;
    step();
    do_start();
    chk("reseed_pattern", pat_a, 4'hA);

    for (int h = 1; h <= 256; h++) begin
      press(m_pat, 1'b0);
      if (h <= 5) chk("early_hit_score", score_a, exp5[h-1]);
`ifndef STREAK_BONUS_EN
      if (h == 254) chk("score_254", score_a, 254);
`endif
      if (h >= 255) chk("score_saturated", score_a, 255);
      release_btn();
    end

    res_a = 1'b0;
    sel = 1;
    model_reset();
    m_rounds = RB;
    step();
    res_b = 1'b1;
    step();
    do_start();
    chk("b_first_pattern", pat_b, 4'hA);
    press(m_pat, 1'b0);
    release_btn();
    press(m_pat, 1'b0);
    release_btn();
    chk("over_flag", over_b, 1);
    chk("over_score", score_b, 2);
    chk("over_pattern", pat_b, 0);
    chk("over_playing", play_b, 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    do_start();
    chk("restart_score", score_b, 0);
    chk("restart_playing", play_b, 1);
    chk("restart_over", over_b, 0);

    chk_en = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
